// File: rtl/jtframe_dualram_arb.sv
// jtframe_dualram_arb
// Shares port 0 of a dual-port block RAM between two requesters (A and B)
// using a cs/ok level handshake, with round-robin arbitration on ties.
// Port 0 of the RAM has a registered read, so q is valid on the clock
// after the address is presented.
//
// Optional feature: define JTFRAME_DUALRAM_ARB_CLR_EN to build a clear
// engine. A rising edge on clr then sweeps every RAM word to CLR_VAL.
// Without the macro, clr is ignored and clr_busy is tied low.
//
// Ports:
//   rst, clk            synchronous active-high reset, single clock
//   a_cs, a_we          requester A request level and write enable
//   a_addr, a_din       requester A address and write data
//   a_dout, a_ok        requester A read data and access-complete flag
//   b_*                 same set of ports for requester B
//   clr, clr_busy       clear start (rising edge) and clear-in-progress flag
//   ram_addr, ram_din   RAM port 0 address and write data
//   ram_we, ram_q       RAM port 0 write enable and read data
module jtframe_dualram_arb #(
    parameter int            dw      = 8,
    parameter int            aw      = 10,
    parameter logic [dw-1:0] CLR_VAL = '0
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          a_cs,
    input  logic          a_we,
    input  logic [aw-1:0] a_addr,
    input  logic [dw-1:0] a_din,
    output logic [dw-1:0] a_dout,
    output logic          a_ok,
    input  logic          b_cs,
    input  logic          b_we,
    input  logic [aw-1:0] b_addr,
    input  logic [dw-1:0] b_din,
    output logic [dw-1:0] b_dout,
    output logic          b_ok,
    input  logic          clr,
    output logic          clr_busy,
    output logic [aw-1:0] ram_addr,
    output logic [dw-1:0] ram_din,
    output logic          ram_we,
    input  logic [dw-1:0] ram_q
);

`ifdef JTFRAME_DUALRAM_ARB_CLR_EN
    typedef enum logic [2:0] { IDLE, ISSUE, WAIT, DONE, CLEAR } state_t;
`else
    typedef enum logic [2:0] { IDLE, ISSUE, WAIT, DONE } state_t;
`endif

    state_t        state_q, state_d;
    logic          lastB_q, lastB_d;
    logic          grantB_q, grantB_d;
    logic          isWr_q, isWr_d;
    logic          aArmed_q, aArmed_d;
    logic          bArmed_q, bArmed_d;
    logic          aOk_q, aOk_d;
    logic          bOk_q, bOk_d;
    logic [dw-1:0] aDout_q, aDout_d;
    logic [dw-1:0] bDout_q, bDout_d;
    logic [aw-1:0] ramAddr_q, ramAddr_d;
    logic [dw-1:0] ramDin_q, ramDin_d;
    logic          ramWe_q, ramWe_d;
    logic          aReq, bReq;

`ifdef JTFRAME_DUALRAM_ARB_CLR_EN
    logic          clrBusy_q, clrBusy_d;
    logic          clrPend_q, clrPend_d;
    logic          clrPrev_q;
    logic          clrRise;

    assign clrRise  = clr & ~clrPrev_q;
    assign clr_busy = clrBusy_q;
`else
    logic          unusedBits;

    assign unusedBits = clr ^ (^CLR_VAL);
    assign clr_busy   = 1'b0;
`endif

    assign a_dout   = aDout_q;
    assign a_ok     = aOk_q;
    assign b_dout   = bDout_q;
    assign b_ok     = bOk_q;
    assign ram_addr = ramAddr_q;
    assign ram_din  = ramDin_q;
    assign ram_we   = ramWe_q;

    // Next-state logic. A requester is armed again only once its cs is seen
    // low, so a held cs produces a single access. Dropping cs also clears ok
    // and, mid-access, suppresses the ok of the access already in flight.
    always_comb begin
        state_d  = state_q;
        lastB_d  = lastB_q;
        grantB_d = grantB_q;
        isWr_d   = isWr_q;
        aArmed_d = aArmed_q;
        bArmed_d = bArmed_q;
        aOk_d    = aOk_q;
        bOk_d    = bOk_q;
        aDout_d  = aDout_q;
        bDout_d  = bDout_q;
        ramAddr_d = ramAddr_q;
        ramDin_d  = ramDin_q;
        ramWe_d   = ramWe_q;
        aReq     = a_cs & aArmed_q;
        bReq     = b_cs & bArmed_q;
`ifdef JTFRAME_DUALRAM_ARB_CLR_EN
        clrBusy_d = clrBusy_q;
        clrPend_d = clrPend_q;
        if (clrRise && state_q != CLEAR) begin
            clrPend_d = 1'b1;
        end
`endif
        if (!a_cs) begin
            aArmed_d = 1'b1;
            aOk_d    = 1'b0;
        end
        if (!b_cs) begin
            bArmed_d = 1'b1;
            bOk_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
`ifdef JTFRAME_DUALRAM_ARB_CLR_EN
                if (clrPend_q) begin
                    state_d   = CLEAR;
                    clrPend_d = 1'b0;
                    clrBusy_d = 1'b1;
                    ramWe_d   = 1'b1;
                    ramAddr_d = '0;
                    ramDin_d  = CLR_VAL;
                end else
`endif
                if (aReq || bReq) begin
                    grantB_d = bReq && !(aReq && lastB_q);
                    lastB_d  = grantB_d;
                    state_d  = ISSUE;
                    if (grantB_d) begin
                        bArmed_d  = 1'b0;
                        ramAddr_d = b_addr;
                        ramDin_d  = b_din;
                        ramWe_d   = b_we;
                        isWr_d    = b_we;
                    end else begin
                        aArmed_d  = 1'b0;
                        ramAddr_d = a_addr;
                        ramDin_d  = a_din;
                        ramWe_d   = a_we;
                        isWr_d    = a_we;
                    end
                end
            end
            ISSUE: begin
                ramWe_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                state_d = DONE;
                if (grantB_q) begin
                    if (!isWr_q) bDout_d = ram_q;
                    if (b_cs && !bArmed_q) bOk_d = 1'b1;
                end else begin
                    if (!isWr_q) aDout_d = ram_q;
                    if (a_cs && !aArmed_q) aOk_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef JTFRAME_DUALRAM_ARB_CLR_EN
            CLEAR: begin
                ramAddr_d = ramAddr_q + aw'(1);
                if (ramAddr_q == '1) begin
                    state_d   = IDLE;
                    ramWe_d   = 1'b0;
                    clrBusy_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any access or sweep immediately; the last
    // served pointer starts at B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lastB_q   <= 1'b1;
            grantB_q  <= 1'b0;
            isWr_q    <= 1'b0;
            aArmed_q  <= 1'b1;
            bArmed_q  <= 1'b1;
            aOk_q     <= 1'b0;
            bOk_q     <= 1'b0;
            aDout_q   <= '0;
            bDout_q   <= '0;
            ramAddr_q <= '0;
            ramDin_q  <= '0;
            ramWe_q   <= 1'b0;
`ifdef JTFRAME_DUALRAM_ARB_CLR_EN
            clrBusy_q <= 1'b0;
            clrPend_q <= 1'b0;
            clrPrev_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lastB_q   <= lastB_d;
            grantB_q  <= grantB_d;
            isWr_q    <= isWr_d;
            aArmed_q  <= aArmed_d;
            bArmed_q  <= bArmed_d;
            aOk_q     <= aOk_d;
            bOk_q     <= bOk_d;
            aDout_q   <= aDout_d;
            bDout_q   <= bDout_d;
            ramAddr_q <= ramAddr_d;
            ramDin_q  <= ramDin_d;
            ramWe_q   <= ramWe_d;
`ifdef JTFRAME_DUALRAM_ARB_CLR_EN
            clrBusy_q <= clrBusy_d;
            clrPend_q <= clrPend_d;
            clrPrev_q <= clr;
`endif
        end
    end

endmodule
